// File: rtl/wb_stage_reg_pkg.sv
// Shared constants for the writeback stage register and its lane canonicaliser.
package wb_stage_reg_pkg;

  localparam int DEF_LANES  = 1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;

  // Register 0 is hardwired, so writes targeting it are turned into NOPs.
  localparam int                    NOP_ADDR      = 0;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD     = '0;

endpackage

// File: rtl/wb_lane_canon.sv
// Canonicalises one writeback lane: writes to the NOP register, or disabled
// writes, become an all-zero lane so downstream never sees stale fields.
module wb_lane_canon
  import wb_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic keep;

  assign keep    = wreg_i && (wd_i != ADDR_W'(NOP_ADDR));
  assign wreg_o  = keep ? 1'b1 : WRITE_DISABLE;
  assign wd_o    = keep ? wd_i : ADDR_W'(NOP_ADDR);
  assign wdata_o = keep ? wdata_i : DATA_W'(ZERO_WORD);

endmodule

// File: rtl/wb_stage_reg.sv
// Writeback stage register: a 2-entry FIFO of canonicalised multi-lane
// register writes, with stall/flush/global-ready control and a retire counter.
module wb_stage_reg
  import wb_stage_reg_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ADDR_W-1:0] in_wd,
  input  logic [LANES-1:0]        in_wreg,
  input  logic [LANES*DATA_W-1:0] in_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ADDR_W-1:0] out_wd,
  output logic [LANES-1:0]        out_wreg,
  output logic [LANES*DATA_W-1:0] out_wdata,
  output logic [CNT_W-1:0]        retire_cnt
);

  logic [1:0][LANES*ADDR_W-1:0] wd_q, wd_d;
  logic [1:0][LANES-1:0]        wreg_q, wreg_d;
  logic [1:0][LANES*DATA_W-1:0] wdata_q, wdata_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   count_q, count_d;
  logic [CNT_W-1:0]             retire_cnt_q, retire_cnt_d;

  logic [LANES*ADDR_W-1:0] cn_wd;
  logic [LANES-1:0]        cn_wreg;
  logic [LANES*DATA_W-1:0] cn_wdata;
  logic                    full, empty, push, pop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wb_lane_canon #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_canon (
      .wd_i    (in_wd[i*ADDR_W +: ADDR_W]),
      .wreg_i  (in_wreg[i]),
      .wdata_i (in_wdata[i*DATA_W +: DATA_W]),
      .wd_o    (cn_wd[i*ADDR_W +: ADDR_W]),
      .wreg_o  (cn_wreg[i]),
      .wdata_o (cn_wdata[i*DATA_W +: DATA_W])
    );
  end

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  // Gating with rst keeps the handshake quiet while the state is being cleared.
  assign in_ready  = !rst && !full && !stall && rdy && !flush;
  assign out_valid = !rst && !empty && !stall;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && rdy && !flush;

  assign out_wd     = out_valid ? wd_q[rd_ptr_q]    : '0;
  assign out_wreg   = out_valid ? wreg_q[rd_ptr_q]  : '0;
  assign out_wdata  = out_valid ? wdata_q[rd_ptr_q] : '0;
  assign retire_cnt = retire_cnt_q;

  always_comb begin
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    retire_cnt_d = retire_cnt_q;
    if (rst) begin
      wd_d         = '0;
      wreg_d       = '0;
      wdata_d      = '0;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      count_d      = 2'd0;
      retire_cnt_d = '0;
    end else if (rdy && flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      // push/pop already fold in rdy, so a low rdy falls through as a hold.
      if (push) begin
        wd_d[wr_ptr_q]    = cn_wd;
        wreg_d[wr_ptr_q]  = cn_wreg;
        wdata_d[wr_ptr_q] = cn_wdata;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d     = ~rd_ptr_q;
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    wd_q         <= wd_d;
    wreg_q       <= wreg_d;
    wdata_q      <= wdata_d;
    wr_ptr_q     <= wr_ptr_d;
    rd_ptr_q     <= rd_ptr_d;
    count_q      <= count_d;
    retire_cnt_q <= retire_cnt_d;
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg: directed scenarios plus random traffic
// against a queue-based reference model of the stage.
module tb_wb_stage_reg;

  localparam int L  = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, stall, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [L*AW-1:0] in_wd, out_wd;
  logic [L-1:0]    in_wreg, out_wreg;
  logic [L*DW-1:0] in_wdata, out_wdata;
  logic [CW-1:0]   retire_cnt;

  wb_stage_reg #(.LANES(L), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic [L*AW-1:0] wd;
    logic [L-1:0]    wreg;
    logic [L*DW-1:0] wdata;
  } ent_t;

  ent_t mq[$];
  int   mret;
  int   errors = 0;
  int   checks = 0;

  function automatic ent_t canon(ent_t e);
    ent_t r;
    r = '0;
    for (int i = 0; i < L; i++)
      if (e.wreg[i] && e.wd[i*AW +: AW] != 0) begin
        r.wd[i*AW +: AW]    = e.wd[i*AW +: AW];
        r.wreg[i]           = 1'b1;
        r.wdata[i*DW +: DW] = e.wdata[i*DW +: DW];
      end
    return r;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    for (int i = 0; i < L; i++) begin
      e.wd[i*AW +: AW]    = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
      e.wreg[i]           = ($urandom_range(0, 3) != 0);
      e.wdata[i*DW +: DW] = $urandom;
    end
    return e;
  endfunction

  function automatic logic exp_out_valid();
    return !rst && mq.size() > 0 && !stall;
  endfunction

  function automatic logic exp_in_ready();
    return !rst && rdy && !flush && !stall && mq.size() < 2;
  endfunction

  function automatic ent_t exp_head();
    if (!exp_out_valid()) return '0;
    return mq[0];
  endfunction

  // Stage behaviour at one clock edge, from the current inputs.
  function automatic void model_edge();
    bit p_pop, p_push;
    p_pop  = mq.size() > 0 && !stall && out_ready;
    p_push = in_valid && mq.size() < 2 && !stall;
    if (rst) begin
      mq.delete();
      mret = 0;
    end else if (rdy && flush) begin
      mq.delete();
    end else if (rdy) begin
      if (p_pop) begin
        void'(mq.pop_front());
        mret = (mret + 1) % (1 << CW);
      end
      if (p_push) mq.push_back(canon('{in_wd, in_wreg, in_wdata}));
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input ent_t e);
    in_valid = v;
    in_wd    = e.wd;
    in_wreg  = e.wreg;
    in_wdata = e.wdata;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; stall = 0; flush = 0; out_ready = 1;
    drive(1'b1, rand_ent());
    step(); step();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if ({out_wd, out_wreg, out_wdata} !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", {out_wd, out_wreg, out_wdata}); end
    checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL rst_retire: got %0d want 0", retire_cnt); end
    rst = 0; in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_wdata !== '0) begin errors++; $display("FAIL post_rst_out_wdata: got %h want 0", out_wdata); end
  endtask

  task automatic test_canon();
    ent_t e;
    e.wd = {5'd0, 5'd3}; e.wreg = 2'b11; e.wdata = {32'd5, 32'hDEADBEEF};
    out_ready = 0;
    drive(1'b1, e);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL canon_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL canon_out_valid: got %b want 1", out_valid); end
    checks++; if (out_wd !== 10'd3) begin errors++; $display("FAIL canon_wd: got %h want 003", out_wd); end
    checks++; if (out_wreg !== 2'b01) begin errors++; $display("FAIL canon_wreg: got %b want 01", out_wreg); end
    checks++; if (out_wdata !== {32'd0, 32'hDEADBEEF}) begin errors++; $display("FAIL canon_wdata: got %h want 00000000deadbeef", out_wdata); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_full();
    ent_t a, b, c, h;
    a = rand_ent(); b = rand_ent(); c = rand_ent();
    out_ready = 0;
    drive(1'b1, a); step();
    drive(1'b1, b); step();
    drive(1'b1, c);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    step();
    in_valid = 0;
    #1;
    h = canon(a);
    checks++; if ({out_wd, out_wreg, out_wdata} !== h) begin errors++; $display("FAIL full_head: got %h want %h", {out_wd, out_wreg, out_wdata}, h); end
    out_ready = 1; step();
    #1;
    h = canon(b);
    checks++; if ({out_wd, out_wreg, out_wdata} !== h) begin errors++; $display("FAIL full_second: got %h want %h", {out_wd, out_wreg, out_wdata}, h); end
    step();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_push_pop();
    ent_t a, b, h;
    int   rb;
    a = rand_ent(); b = rand_ent();
    out_ready = 0;
    drive(1'b1, a); step();
    rb = mret;
    drive(1'b1, b); out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 0; out_ready = 0;
    #1;
    h = canon(b);
    checks++; if ({out_wd, out_wreg, out_wdata} !== h) begin errors++; $display("FAIL pp_head: got %h want %h", {out_wd, out_wreg, out_wdata}, h); end
    checks++; if (retire_cnt !== CW'(rb + 1)) begin errors++; $display("FAIL pp_retire: got %0d want %0d", retire_cnt, CW'(rb + 1)); end
    out_ready = 1; step();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_occupancy: got %b want 0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_flush_stall();
    int rb;
    out_ready = 0;
    drive(1'b1, rand_ent()); step();
    drive(1'b1, rand_ent()); step();
    rb = mret;
    flush = 1; stall = 1; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fs_in_ready: got %b want 0", in_ready); end
    step();
    flush = 0; stall = 0; in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fs_out_valid: got %b want 0", out_valid); end
    checks++; if (out_wdata !== '0) begin errors++; $display("FAIL fs_out_wdata: got %h want 0", out_wdata); end
    checks++; if (retire_cnt !== CW'(rb)) begin errors++; $display("FAIL fs_retire: got %0d want %0d", retire_cnt, CW'(rb)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fs_ready_after: got %b want 1", in_ready); end
    out_ready = 0;
  endtask

  task automatic test_rdy_hold();
    ent_t a, b, h;
    int   rb;
    a = rand_ent(); b = rand_ent();
    out_ready = 0;
    drive(1'b1, a); step();
    rb = mret;
    rdy = 0; drive(1'b1, b); out_ready = 1;
    h = canon(a);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready); end
      checks++; if ({out_valid, out_wd, out_wreg, out_wdata} !== {1'b1, h}) begin errors++; $display("FAIL hold_head[%0d]: got %h want %h", k, {out_valid, out_wd, out_wreg, out_wdata}, {1'b1, h}); end
      checks++; if (retire_cnt !== CW'(rb)) begin errors++; $display("FAIL hold_retire[%0d]: got %0d want %0d", k, retire_cnt, CW'(rb)); end
      step();
    end
    rdy = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL resume_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 0; out_ready = 0;
    #1;
    h = canon(b);
    checks++; if ({out_wd, out_wreg, out_wdata} !== h) begin errors++; $display("FAIL resume_head: got %h want %h", {out_wd, out_wreg, out_wdata}, h); end
    checks++; if (retire_cnt !== CW'(rb + 1)) begin errors++; $display("FAIL resume_retire: got %0d want %0d", retire_cnt, CW'(rb + 1)); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_wrap_and_reset();
    rst = 1; step(); rst = 0;
    out_ready = 1;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, rand_ent());
      #1;
      checks++; if (retire_cnt !== CW'(mret)) begin errors++; $display("FAIL wrap_retire[%0d]: got %0d want %0d", k, retire_cnt, CW'(mret)); end
      step();
    end
    #1;
    checks++; if (retire_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", retire_cnt); end
    rst = 1;
    step();
    #1;
    checks++; if ({in_ready, out_valid, out_wd, out_wreg, out_wdata, retire_cnt} !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", {in_ready, out_valid, out_wd, out_wreg, out_wdata, retire_cnt}); end
    rst = 0; in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %b want 0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_random();
    ent_t h;
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      rdy       = ($urandom_range(0, 4) != 0);
      stall     = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = $urandom_range(0, 1);
      drive($urandom_range(0, 2) != 0, rand_ent());
      #1;
      h = exp_head();
      checks++; if (in_ready !== exp_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", k, in_ready, exp_in_ready()); end
      checks++; if (out_valid !== exp_out_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", k, out_valid, exp_out_valid()); end
      checks++; if ({out_wd, out_wreg, out_wdata} !== h) begin errors++; $display("FAIL rnd_head[%0d]: got %h want %h", k, {out_wd, out_wreg, out_wdata}, h); end
      checks++; if (retire_cnt !== CW'(mret)) begin errors++; $display("FAIL rnd_retire[%0d]: got %0d want %0d", k, retire_cnt, CW'(mret)); end
      step();
    end
    rst = 0; rdy = 1; stall = 0; flush = 0; in_valid = 0; out_ready = 0;
  endtask

  initial begin
    mret = 0;
    test_reset();
    test_canon();
    test_full();
    test_push_pop();
    test_flush_stall();
    test_rdy_hold();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
